// File: rtl/sublime_phase_pkg.sv
// Shared types for the phase sweeper: sequencer states and voice-count helper.
package sublime_phase_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int unsigned voice_count(input int unsigned voice_bits);
        return 32'd1 << voice_bits;
    endfunction

endpackage

// File: rtl/sublime_phase_inc_regs.sv
// Per-voice increment register file: one synchronous write port, one combinational read port.
// Read reflects writes from the cycle after the write edge.
module sublime_phase_inc_regs
    import sublime_phase_pkg::*;
#(
    parameter int VOICE_BITS  = 3,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [VOICE_BITS-1:0]  waddr,
    input  logic [PHASE_WIDTH-1:0] wdata,
    input  logic [VOICE_BITS-1:0]  raddr,
    output logic [PHASE_WIDTH-1:0] rdata
);
    localparam int N = int'(voice_count(VOICE_BITS));

    logic [PHASE_WIDTH-1:0] regs [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/sublime_phase_sweeper.sv
// Per-voice phase accumulator: zeroes the external RAM after reset, then on each tick
// read-modify-writes every voice (phase += inc) and streams the results, N+2 cycles per sweep.
module sublime_phase_sweeper
    import sublime_phase_pkg::*;
#(
    parameter int VOICE_BITS  = 3,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   inc_we,
    input  logic [VOICE_BITS-1:0]  inc_voice,
    input  logic [PHASE_WIDTH-1:0] inc_value,
    input  logic                   overrun_clr,
    output logic [VOICE_BITS-1:0]  ram_raddr,
    output logic [VOICE_BITS-1:0]  ram_waddr,
    output logic                   ram_we,
    output logic [PHASE_WIDTH-1:0] ram_din,
    input  logic [PHASE_WIDTH-1:0] ram_dout,
    output logic                   phase_valid,
    output logic [VOICE_BITS-1:0]  phase_voice,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   busy,
    output logic                   overrun
);
    localparam int              N    = int'(voice_count(VOICE_BITS));
    localparam [VOICE_BITS-1:0] LAST = VOICE_BITS'(N - 1);

    state_t                 state;
    logic [VOICE_BITS-1:0]  clr_cnt;
    logic [VOICE_BITS-1:0]  rd_addr;
    logic [VOICE_BITS-1:0]  wb_idx;
    logic                   wb_vld;
    logic [PHASE_WIDTH-1:0] inc_rd;
    logic [PHASE_WIDTH-1:0] wb_sum;
    logic                   tick_dropped;

    sublime_phase_inc_regs #(
        .VOICE_BITS  (VOICE_BITS),
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_inc_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (inc_we),
        .waddr (inc_voice),
        .wdata (inc_value),
        .raddr (wb_idx),
        .rdata (inc_rd)
    );

    // RAM data for voice i arrives one cycle after its read, so write-back trails the read by one.
    assign wb_sum       = ram_dout + inc_rd;
    assign tick_dropped = sample_tick && (state == ST_SWEEP || state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_cnt     <= '0;
            rd_addr     <= '0;
            wb_idx      <= '0;
            wb_vld      <= 1'b0;
            phase_valid <= 1'b0;
            phase_voice <= '0;
            phase_out   <= '0;
            overrun     <= 1'b0;
        end else begin
            wb_vld      <= (state == ST_SWEEP);
            wb_idx      <= rd_addr;
            phase_valid <= wb_vld;
            if (wb_vld) begin
                phase_voice <= wb_idx;
                phase_out   <= wb_sum;
            end

            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sample_tick) begin
                        state   <= ST_SWEEP;
                        rd_addr <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (rd_addr == LAST) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: state <= ST_IDLE;
                default:  state <= ST_CLEAR;
            endcase

            // A set in the same cycle as a clear must win.
            if (tick_dropped) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wb_idx;
        ram_din   = wb_sum;
        if (state == ST_CLEAR) begin
            // Held reset keeps the RAM untouched; clearing starts once reset is released.
            ram_we    = !rst;
            ram_waddr = clr_cnt;
            ram_din   = '0;
        end else begin
            ram_we = wb_vld;
        end
    end

    assign ram_raddr = rd_addr;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sublime_phase_sweeper.sv
// Randomised scoreboard bench for the phase sweeper with a behavioural RAM and timeline model.
module tb_sublime_phase_sweeper;
    localparam int VB = 3;
    localparam int PW = 32;
    localparam int N  = 1 << VB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_tick = 1'b0;
    logic          inc_we = 1'b0;
    logic [VB-1:0] inc_voice = '0;
    logic [PW-1:0] inc_value = '0;
    logic          overrun_clr = 1'b0;
    logic [VB-1:0] ram_raddr, ram_waddr, phase_voice;
    logic          ram_we, phase_valid, busy, overrun;
    logic [PW-1:0] ram_din, ram_dout, phase_out;
    logic          seed_mem = 1'b1;
    logic [PW-1:0] mem [N];

    int checks = 0;
    int errors = 0;

    sublime_phase_sweeper #(.VOICE_BITS(VB), .PHASE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .inc_we      (inc_we),
        .inc_voice   (inc_voice),
        .inc_value   (inc_value),
        .overrun_clr (overrun_clr),
        .ram_raddr   (ram_raddr),
        .ram_waddr   (ram_waddr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .phase_valid (phase_valid),
        .phase_voice (phase_voice),
        .phase_out   (phase_out),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // External simple dual-port RAM, registered read; starts with garbage so the clear is visible.
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < N; i++) mem[i] <= $urandom | 32'h1;
            ram_dout <= 32'hDEAD_BEEF;
        end else begin
            if (ram_we) mem[ram_waddr] <= ram_din;
            ram_dout <= mem[ram_raddr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline bookkeeping in edge numbers plus per-voice phase/increment arrays.
    typedef struct {
        int            edge_n;
        int            voice;
        logic [PW-1:0] ph;
    } exp_t;

    exp_t          q[$];
    int            ecnt = 0;
    int            last_rst = -1000;
    int            clear_until = 0;
    int            idle_from = 1 << 30;
    int            sweep_s = -1000;
    bit            started = 0;
    logic          ovr_m = 1'b0;
    logic [PW-1:0] ph_m [N];
    logic [PW-1:0] inc_m [N];

    initial begin
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) begin
                started     = 1;
                last_rst    = ecnt;
                q.delete();
                for (int i = 0; i < N; i++) begin
                    ph_m[i]  = '0;
                    inc_m[i] = '0;
                end
                ovr_m       = 1'b0;
                sweep_s     = -1000;
                idle_from   = ecnt + N + 1;
                clear_until = ecnt + N;
            end else if (started) begin
                if (ecnt >= sweep_s + 2 && ecnt <= sweep_s + N + 1) begin
                    int v;
                    v = ecnt - sweep_s - 2;
                    ph_m[v] = ph_m[v] + inc_m[v];
                    q.push_back('{ecnt, v, ph_m[v]});
                end
                if (sample_tick && ecnt > clear_until && ecnt < idle_from) ovr_m = 1'b1;
                else if (overrun_clr) ovr_m = 1'b0;
                if (sample_tick && ecnt >= idle_from) begin
                    sweep_s   = ecnt;
                    idle_from = ecnt + N + 2;
                end
                if (inc_we) inc_m[inc_voice] = inc_value;
            end
        end
    end

    // Monitor: compares every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("busy", 64'(busy), 64'(ecnt < idle_from - 1));
                chk("overrun", 64'(overrun), 64'(ovr_m));
                if (!rst && ecnt - last_rst >= 0 && ecnt - last_rst < N) begin
                    chk("clear_we", 64'(ram_we), 64'd1);
                    chk("clear_waddr", 64'(ram_waddr), 64'(ecnt - last_rst));
                    chk("clear_din", 64'(ram_din), 64'd0);
                end else if (ecnt >= sweep_s + 1 && ecnt <= sweep_s + N) begin
                    chk("wb_we", 64'(ram_we), 64'd1);
                    chk("wb_waddr", 64'(ram_waddr), 64'(ecnt - sweep_s - 1));
                end else begin
                    chk("we_idle", 64'(ram_we), 64'd0);
                end
                if (q.size() > 0 && q[0].edge_n < ecnt) begin
                    chk("beat_missing", 64'(phase_valid), 64'd1);
                    void'(q.pop_front());
                end
                if (phase_valid) begin
                    if (q.size() == 0 || q[0].edge_n != ecnt) begin
                        chk("beat_unexpected", 64'(phase_valid), 64'd0);
                    end else begin
                        chk("phase_voice", 64'(phase_voice), 64'(q[0].voice));
                        chk("phase_out", 64'(phase_out), 64'(q[0].ph));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_inc(input int v, input logic [PW-1:0] val);
        inc_we    = 1'b1;
        inc_voice = VB'(v);
        inc_value = val;
        step();
        inc_we    = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 60) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_idle();
    endtask

    initial begin
        step();
        seed_mem = 1'b0;
        step();
        step();
        rst = 1'b0;
        wait_idle();
        for (int i = 0; i < N; i++) chk("mem_cleared", 64'(mem[i]), 64'd0);

        for (int v = 0; v < N; v++) write_inc(v, PW'(v * 32'h100));
        tick();
        wait_idle();
        tick();
        wait_idle();

        do_reset();
        write_inc(5, 32'hFFFF_FFF0);
        write_inc(2, 32'h0000_0003);
        tick();
        wait_idle();
        tick();
        wait_idle();

        sample_tick = 1'b1;
        for (int k = 0; k < 35; k++) begin
            overrun_clr = (k == 15);
            step();
        end
        overrun_clr = 1'b0;
        sample_tick = 1'b0;
        wait_idle();
        chk("overrun_held", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 64'(overrun), 64'd0);

        write_inc(3, 32'h0000_1000);
        tick();
        for (int k = 0; k < 4; k++) step();
        write_inc(3, 32'h0005_0000);
        wait_idle();
        tick();
        wait_idle();

        tick();
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle();
        for (int v = 0; v < N; v++) write_inc(v, $urandom);
        tick();
        wait_idle();

        for (int k = 0; k < 400; k++) begin
            sample_tick = ($urandom_range(0, 3) == 0);
            overrun_clr = ($urandom_range(0, 7) == 0);
            inc_we      = ($urandom_range(0, 4) == 0);
            inc_voice   = VB'($urandom_range(0, N - 1));
            inc_value   = $urandom;
            step();
        end
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        inc_we      = 1'b0;
        wait_idle();
        step();
        step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
